// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
// Shared types and constants for the multicycle multiply/divide unit.
//   mdu_op_t    : operation encoding as presented on the op port
//   mdu_state_t : sequencer states of the unit
//   MDU_ITER    : number of CALC iterations per operation (equals WIDTH)
// ---------------------------------------------------------------------------
package mdu_pkg;

    localparam int unsigned MDU_ITER = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } mdu_state_t;

endpackage

// File: rtl/mdu_div_step.sv
// ---------------------------------------------------------------------------
// mdu_div_step
// One combinational restoring-division step: the partial remainder is
// shifted left by one with the next dividend bit, the divisor is trial
// subtracted, and the subtraction is kept only when it does not borrow.
//   rem      in   partial remainder (always < divisor on entry)
//   dvd_bit  in   next dividend bit, MSB first
//   divisor  in   divisor magnitude
//   rem_next out  updated partial remainder
//   q_bit    out  quotient bit produced by this step
// ---------------------------------------------------------------------------
module mdu_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted  = {rem, dvd_bit};
        diff     = shifted - {1'b0, divisor};
        // shifted < 2*divisor, so a borrow shows up as the MSB of diff
        q_bit    = ~diff[WIDTH];
        rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/mdu_hilo_unit.sv
// ---------------------------------------------------------------------------
// mdu_hilo_unit
// Multicycle multiply/divide unit holding the HI/LO register pair of the
// multicycle MIPS datapath. Signed operations work on magnitudes and fix
// the sign in the FIX state. Multiply is shift-add, divide is restoring;
// both share one 2*WIDTH working register.
//
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   asynchronous, active-high reset
//   start    in   launch pulse, sampled only in IDLE
//   op       in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b     in   rs / rt operands
//   hi_we    in   MTHI write enable (IDLE only, start has priority)
//   lo_we    in   MTLO write enable (IDLE only, start has priority)
//   wdata    in   MTHI/MTLO data
//   busy     out  high in CALC and FIX
//   done     out  one-cycle pulse; HI/LO already hold the result
//   div_zero out  sticky: last divide had b == 0; cleared on next start
//   hi, lo   out  HI / LO registers
//
// Build option:
//   MDU_EARLY_TERM_EN - multiply leaves CALC once the unconsumed multiplier
//   bits are all zero (at least one CALC cycle); the product is realigned
//   in FIX. Division timing is unaffected.
// ---------------------------------------------------------------------------
module mdu_hilo_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = MDU_ITER
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned      CNT_W    = $clog2(ITER);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    mdu_state_t         state;
    mdu_state_t         state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;       // mult: {acc, multiplier}; div: {rem, dividend/quotient}
    logic [WIDTH-1:0]   opnd;      // mult: multiplicand magnitude; div: divisor magnitude
    logic               is_div_q;
    logic               neg_res;   // negate product or quotient
    logic               neg_rem;   // negate remainder

    // -----------------------------------------------------------------------
    // Operand decode for the launch cycle
    // -----------------------------------------------------------------------
    mdu_op_t            op_in;
    logic               in_div;
    logic               in_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               accept;
    logic               div_by_zero;

    always_comb begin
        op_in     = mdu_op_t'(op);
        in_div    = 1'b0;
        in_signed = 1'b0;
        case (op_in)
            MDU_MULT:  in_signed = 1'b1;
            MDU_MULTU: in_signed = 1'b0;
            MDU_DIV: begin
                in_div    = 1'b1;
                in_signed = 1'b1;
            end
            MDU_DIVU:  in_div = 1'b1;
            default: begin
                in_div    = 1'b0;
                in_signed = 1'b0;
            end
        endcase
        a_neg       = in_signed & a[WIDTH-1];
        b_neg       = in_signed & b[WIDTH-1];
        a_mag       = a_neg ? -a : a;
        b_mag       = b_neg ? -b : b;
        accept      = (state == IDLE) && start;
        div_by_zero = in_div && (b == '0);
    end

    // -----------------------------------------------------------------------
    // One CALC iteration
    // -----------------------------------------------------------------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step_next;
    logic [WIDTH-1:0]   div_rem;
    logic               div_qbit;

    mdu_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem      (acc[2*WIDTH-1:WIDTH]),
        .dvd_bit  (acc[WIDTH-1]),
        .divisor  (opnd),
        .rem_next (div_rem),
        .q_bit    (div_qbit)
    );

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        // shift {carry, sum, multiplier} right by one
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        // quotient bits enter at the bottom as dividend bits leave the top
        div_next  = {div_rem, acc[WIDTH-2:0], div_qbit};
        step_next = is_div_q ? div_next : mul_next;
    end

    // -----------------------------------------------------------------------
    // CALC exit condition and product alignment
    // -----------------------------------------------------------------------
    logic               calc_exit;
    logic [2*WIDTH-1:0] prod_mag;

`ifdef MDU_EARLY_TERM_EN
    localparam int unsigned CNT_W1 = CNT_W + 1;
    logic [WIDTH-1:0] pending_mask;

    always_comb begin
        // after step cnt, the low WIDTH-cnt-1 bits still hold unused multiplier bits
        pending_mask = {WIDTH{1'b1}} >> ({1'b0, cnt} + CNT_W1'(1));
        calc_exit    = (cnt == LAST_CNT) ||
                       (!is_div_q && ((step_next[WIDTH-1:0] & pending_mask) == '0));
        // skipped iterations would only have shifted zeros in from the top
        prod_mag     = acc >> (LAST_CNT - cnt);
    end
`else
    always_comb begin
        calc_exit = (cnt == LAST_CNT);
        prod_mag  = acc;
    end
`endif

    // -----------------------------------------------------------------------
    // Sign correction applied in FIX
    // -----------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_res;
    logic [WIDTH-1:0]   quot_res;
    logic [WIDTH-1:0]   rem_res;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    always_comb begin
        prod_res = neg_res ? -prod_mag : prod_mag;
        quot_res = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_res  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (is_div_q) begin
            fix_hi = rem_res;
            fix_lo = quot_res;
        end else begin
            fix_hi = prod_res[2*WIDTH-1:WIDTH];
            fix_lo = prod_res[WIDTH-1:0];
        end
    end

    // -----------------------------------------------------------------------
    // Sequencer
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = div_by_zero ? DONE : CALC;
            CALC:    if (calc_exit) state_nx = FIX;
            FIX:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC) || (state == FIX);
        done = (state == DONE);
    end

    // -----------------------------------------------------------------------
    // Datapath and HI/LO registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div_q <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt      <= '0;
                        is_div_q <= in_div;
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        div_zero <= div_by_zero;
                        if (in_div) begin
                            acc  <= {{WIDTH{1'b0}}, a_mag};
                            opnd <= b_mag;
                        end else begin
                            acc  <= {{WIDTH{1'b0}}, b_mag};
                            opnd <= a_mag;
                        end
                        if (div_by_zero) begin
                            hi <= a;
                            lo <= '1;
                        end
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                CALC: begin
                    acc <= step_next;
                    if (!calc_exit) cnt <= cnt + CNT_W'(1);
                end
                FIX: begin
                    hi <= fix_hi;
                    lo <= fix_lo;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
